// File: rtl/player_motion.sv
// Walking, ballistic jump and one-per-jump timed smash for the right-court volleyball player.
// All motion advances only on i_frame_tick; every output comes straight from a register.
module player_motion #(
    parameter logic [9:0] X_MIN        = 10'd170,
    parameter logic [9:0] X_MAX        = 10'd300,
    parameter logic [9:0] START_X      = 10'd210,
    parameter logic [9:0] GROUND_Y     = 10'd220,
    parameter int         WALK_SPEED   = 4,
    parameter int         JUMP_V0      = 12,
    parameter int         GRAVITY      = 1,
    parameter int         SMASH_FRAMES = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_tick,
    input  logic       i_move_left,
    input  logic       i_move_right,
    input  logic       i_jump,
    input  logic       i_smash,
    output logic [9:0] o_pos_x,
    output logic [9:0] o_pos_y,
    output logic       o_airborne,
    output logic       o_smashing,
    output logic       o_landed
);

    // state        | meaning
    // ST_GROUND    | standing on GROUND_Y, jump accepted, smash ignored
    // ST_AIR       | ballistic flight, smash accepted once per jump
    // ST_AIR_SMASH | flight with smash active, r_smash_cnt counts down to 0

    typedef enum logic [1:0] {
        ST_GROUND    = 2'd0,
        ST_AIR       = 2'd1,
        ST_AIR_SMASH = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(SMASH_FRAMES + 1);

    localparam logic signed [10:0]     L_WALK     = 11'(WALK_SPEED);
    localparam logic signed [10:0]     L_X_MIN    = $signed({1'b0, X_MIN});
    localparam logic signed [10:0]     L_X_MAX    = $signed({1'b0, X_MAX});
    localparam logic signed [10:0]     L_GROUND_Y = $signed({1'b0, GROUND_Y});
    localparam logic signed [7:0]      L_V0       = 8'(JUMP_V0);
    localparam logic signed [7:0]      L_GRAVITY  = 8'(GRAVITY);
    localparam logic [CNT_W-1:0]       L_CNT_INIT = CNT_W'(SMASH_FRAMES - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [9:0]             r_pos_x;
    logic signed [10:0]     r_y;
    logic signed [7:0]      r_vy;
    logic                   r_smash_used;
    logic [CNT_W-1:0]       r_smash_cnt;
    logic                   r_airborne;
    logic                   r_smashing;
    logic                   r_landed;

    logic signed [10:0]     w_x_cur;
    logic signed [10:0]     w_x_left;
    logic signed [10:0]     w_x_right;
    logic signed [10:0]     w_y_calc;
    logic                   w_land;
    logic                   w_smash_start;

    logic [9:0]             w_x_next;
    logic signed [10:0]     w_y_next;
    logic signed [7:0]      w_vy_next;
    logic                   w_used_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_landed_next;

    // 11-bit signed arithmetic keeps a step past either clamp from wrapping
    assign w_x_cur   = $signed({1'b0, r_pos_x});
    assign w_x_left  = w_x_cur - L_WALK;
    assign w_x_right = w_x_cur + L_WALK;
    assign w_y_calc  = r_y - {{3{r_vy[7]}}, r_vy};
    assign w_land    = (w_y_calc >= L_GROUND_Y);

    assign w_smash_start = (r_state == ST_AIR) && !w_land && i_smash && !r_smash_used;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_GROUND;
            r_pos_x      <= START_X;
            r_y          <= L_GROUND_Y;
            r_vy         <= '0;
            r_smash_used <= 1'b0;
            r_smash_cnt  <= '0;
            r_airborne   <= 1'b0;
            r_smashing   <= 1'b0;
            r_landed     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pos_x      <= w_x_next;
            r_y          <= w_y_next;
            r_vy         <= w_vy_next;
            r_smash_used <= w_used_next;
            r_smash_cnt  <= w_cnt_next;
            r_airborne   <= (w_state_next != ST_GROUND);
            r_smashing   <= (w_state_next == ST_AIR_SMASH);
            r_landed     <= w_landed_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_frame_tick) begin
            case (r_state)
                ST_GROUND: begin
                    if (i_jump) w_state_next = ST_AIR;
                end
                ST_AIR: begin
                    if (w_land)             w_state_next = ST_GROUND;
                    else if (w_smash_start) w_state_next = ST_AIR_SMASH;
                end
                ST_AIR_SMASH: begin
                    if (w_land)                 w_state_next = ST_GROUND;
                    else if (r_smash_cnt == '0) w_state_next = ST_AIR;
                end
                default: w_state_next = ST_GROUND;
            endcase
        end
    end

    always_comb begin
        w_x_next      = r_pos_x;
        w_y_next      = r_y;
        w_vy_next     = r_vy;
        w_used_next   = r_smash_used;
        w_cnt_next    = r_smash_cnt;
        w_landed_next = 1'b0;

        if (i_frame_tick) begin
            if (i_move_left && !i_move_right) begin
                w_x_next = (w_x_left < L_X_MIN) ? X_MIN : w_x_left[9:0];
            end else if (i_move_right && !i_move_left) begin
                w_x_next = (w_x_right > L_X_MAX) ? X_MAX : w_x_right[9:0];
            end

            case (r_state)
                ST_GROUND: begin
                    if (i_jump) begin
                        w_vy_next   = L_V0;
                        w_used_next = 1'b0;
                    end
                end
                ST_AIR, ST_AIR_SMASH: begin
                    if (w_land) begin
                        w_y_next      = L_GROUND_Y;
                        w_vy_next     = '0;
                        w_cnt_next    = '0;
                        w_landed_next = 1'b1;
                    end else begin
                        w_y_next  = (w_y_calc < 11'sd0) ? 11'sd0 : w_y_calc;
                        w_vy_next = r_vy - L_GRAVITY;
                        if (w_smash_start) begin
                            w_cnt_next  = L_CNT_INIT;
                            w_used_next = 1'b1;
                        end else if (r_state == ST_AIR_SMASH && r_smash_cnt != '0) begin
                            w_cnt_next = r_smash_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    w_vy_next = '0;
                end
            endcase
        end
    end

    assign o_pos_x    = r_pos_x;
    assign o_pos_y    = r_y[9:0];
    assign o_airborne = r_airborne;
    assign o_smashing = r_smashing;
    assign o_landed   = r_landed;

endmodule
